// File: rtl/arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : arb_mux
// Purpose  : Registered N-channel arbitrating mux with valid/ready handshakes,
//            fixed-priority or round-robin selection and packet locking.
// Revision : 1.0 - initial release
// ============================================================================
module arb_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int MODE  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N-1:0]            in_valid,
  input  logic [N*WIDTH-1:0]      in_data,
  input  logic [N-1:0]            in_last,
  output logic [N-1:0]            in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_last,
  output logic [$clog2(N)-1:0]    out_sel,
  input  logic                    out_ready
);

  localparam int SELW = $clog2(N);

  localparam logic [0:0] c_unlocked = 1'b0;
  localparam logic [0:0] c_locked   = 1'b1;

  logic [0:0]       r_state;
  logic [SELW-1:0]  r_owner;
  logic [SELW-1:0]  r_ptr;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_last;
  logic [SELW-1:0]  r_out_sel;

  logic [WIDTH-1:0] w_ch_data [N];
  logic [N-1:0]     w_grant;
  logic             w_any;
  logic [SELW-1:0]  w_gidx;
  logic [WIDTH-1:0] w_gdata;
  logic             w_glast;
  logic             w_load;
  logic             w_accept;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_unpack
      assign w_ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Grant is one-hot or zero; a lock pins it to the owner even when idle.
  always_comb begin : p_grant
    int   idx;
    logic found;
    w_grant = '0;
    found   = 1'b0;
    idx     = 0;
    if (r_state == c_locked) begin
      for (int i = 0; i < N; i++) begin
        if (SELW'(i) == r_owner) begin
          w_grant[i] = in_valid[i];
        end
      end
    end else if (MODE == 0) begin
      for (int i = 0; i < N; i++) begin
        if (!found && in_valid[i]) begin
          w_grant[i] = 1'b1;
          found      = 1'b1;
        end
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        idx = int'(r_ptr) + k;
        if (idx >= N) begin
          idx = idx - N;
        end
        if (!found && in_valid[idx]) begin
          w_grant[idx] = 1'b1;
          found        = 1'b1;
        end
      end
    end
  end

  always_comb begin : p_encode
    w_gidx  = '0;
    w_gdata = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant[i]) begin
        w_gidx  = w_gidx | SELW'(i);
        w_gdata = w_gdata | w_ch_data[i];
      end
    end
  end

  assign w_any    = |w_grant;
  assign w_glast  = |(w_grant & in_last);
  assign w_load   = ~r_out_valid | out_ready;
  assign w_accept = w_load & w_any;
  assign in_ready = w_load ? w_grant : '0;

  always_ff @(posedge clk) begin : p_out
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_sel   <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_gdata;
      r_out_last  <= w_glast;
      r_out_sel   <= w_gidx;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // While locked, an accept can only come from the owner.
  always_ff @(posedge clk) begin : p_lock
    if (rst) begin
      r_state <= c_unlocked;
      r_owner <= '0;
    end else if (w_accept) begin
      case (r_state)
        c_unlocked: begin
          if (!w_glast) begin
            r_state <= c_locked;
            r_owner <= w_gidx;
          end
        end
        c_locked: begin
          if (w_glast) begin
            r_state <= c_unlocked;
          end
        end
        default: r_state <= c_unlocked;
      endcase
    end
  end

  always_ff @(posedge clk) begin : p_ptr
    if (rst) begin
      r_ptr <= '0;
    end else if ((MODE == 1) && w_accept && w_glast) begin
      if (w_gidx == SELW'(N - 1)) begin
        r_ptr <= '0;
      end else begin
        r_ptr <= w_gidx + 1'b1;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_sel   = r_out_sel;

endmodule
`default_nettype wire

// File: tb/tb_arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_arb_mux
// Purpose  : Directed self-checking bench for arb_mux (round-robin and
//            fixed-priority instances driven from shared stimulus).
// Revision : 1.0 - initial release
// ============================================================================
module tb_arb_mux;

  localparam int WIDTH = 32;
  localparam int N     = 4;

  logic             clk;
  logic             rst;
  logic [N-1:0]     in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]     in_last;
  logic             out_ready;

  logic [N-1:0]     rr_in_ready,  fp_in_ready;
  logic             rr_out_valid, fp_out_valid;
  logic [WIDTH-1:0] rr_out_data,  fp_out_data;
  logic             rr_out_last,  fp_out_last;
  logic [1:0]       rr_out_sel,   fp_out_sel;

  int n_vec;
  int n_err;

  arb_mux #(.WIDTH(WIDTH), .N(N), .MODE(1)) dut_rr (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(rr_in_ready),
    .out_valid(rr_out_valid), .out_data(rr_out_data),
    .out_last(rr_out_last), .out_sel(rr_out_sel),
    .out_ready(out_ready)
  );

  arb_mux #(.WIDTH(WIDTH), .N(N), .MODE(0)) dut_fp (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(fp_in_ready),
    .out_valid(fp_out_valid), .out_data(fp_out_data),
    .out_last(fp_out_last), .out_sel(fp_out_sel),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int i, input logic [WIDTH-1:0] d);
    in_data[i*WIDTH +: WIDTH] = d;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    in_valid  = 4'b1111;
    in_last   = 4'b1111;
    out_ready = 1'b1;
    in_data   = '0;
    for (int i = 0; i < N; i++) set_ch(i, 32'hA0 + i);

    // Reset held for two edges with every channel valid
    tick;
    tick;
    chk("rst_valid", rr_out_valid, 1'b0);
    chk("rst_sel",   rr_out_sel,   2'd0);
    chk("rst_data",  rr_out_data,  32'h0);
    chk("rst_last",  rr_out_last,  1'b0);
    chk("fp_rst_valid", fp_out_valid, 1'b0);
    rst = 1'b0;
    #1;
    chk("rst_ready_rr", rr_in_ready, 4'b0001);
    chk("rst_ready_fp", fp_in_ready, 4'b0001);

    // Round-robin rotation over single-beat packets
    for (int k = 0; k < 8; k++) begin
      tick;
      chk("rr_valid", rr_out_valid, 1'b1);
      chk("rr_sel",   rr_out_sel,   k % 4);
      chk("rr_data",  rr_out_data,  32'hA0 + (k % 4));
      chk("rr_last",  rr_out_last,  1'b1);
      chk("rr_ready", rr_in_ready,  4'b0001 << ((k + 1) % 4));
      chk("fp_sel_all", fp_out_sel, 2'd0);
      chk("fp_ready_all", fp_in_ready, 4'b0001);
    end

    // Fixed priority with channels 1 and 3 contending
    in_valid = 4'b1010;
    #1;
    chk("fp_ready13", fp_in_ready, 4'b0010);
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("fp_sel13",   fp_out_sel,  2'd1);
      chk("fp_data13",  fp_out_data, 32'hA1);
      chk("fp_ready13", fp_in_ready, 4'b0010);
    end

    // Move the round-robin pointer to 2 with a single beat from channel 1
    in_valid = 4'b0010;
    tick;
    chk("ptr_sel1", rr_out_sel, 2'd1);

    // Three-beat packet on channel 2 while channel 0 waits
    in_valid = 4'b0101;
    in_last  = 4'b1011;
    set_ch(2, 32'hC0);
    set_ch(0, 32'hD0);
    #1;
    chk("lk_ready0", rr_in_ready, 4'b0100);
    tick;
    chk("lk_sel0",  rr_out_sel,  2'd2);
    chk("lk_data0", rr_out_data, 32'hC0);
    chk("lk_last0", rr_out_last, 1'b0);
    in_valid = 4'b0001;
    #1;
    chk("lk_idle_a", rr_in_ready, 4'b0000);
    tick;
    chk("lk_drain", rr_out_valid, 1'b0);
    chk("lk_idle_b", rr_in_ready, 4'b0000);
    tick;
    chk("lk_idle_c", rr_in_ready, 4'b0000);
    in_valid = 4'b0101;
    set_ch(2, 32'hC1);
    #1;
    chk("lk_ready1", rr_in_ready, 4'b0100);
    tick;
    chk("lk_sel1",  rr_out_sel,  2'd2);
    chk("lk_data1", rr_out_data, 32'hC1);
    set_ch(2, 32'hC2);
    in_last = 4'b1111;
    #1;
    chk("lk_ready2", rr_in_ready, 4'b0100);
    tick;
    chk("lk_sel2",  rr_out_sel,  2'd2);
    chk("lk_data2", rr_out_data, 32'hC2);
    chk("lk_last2", rr_out_last, 1'b1);
    chk("lk_switch", rr_in_ready, 4'b0001);
    tick;
    chk("lk_sel_next",  rr_out_sel,  2'd0);
    chk("lk_data_next", rr_out_data, 32'hD0);

    // Backpressure: beat from channel 0 held, channel 1 waiting
    out_ready = 1'b0;
    in_valid  = 4'b0010;
    set_ch(1, 32'hD1);
    #1;
    chk("bp_ready_rr", rr_in_ready, 4'b0000);
    chk("bp_ready_fp", fp_in_ready, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      tick;
      chk("bp_valid", rr_out_valid, 1'b1);
      chk("bp_data",  rr_out_data,  32'hD0);
      chk("bp_sel",   rr_out_sel,   2'd0);
      chk("bp_ready", rr_in_ready,  4'b0000);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release", rr_in_ready, 4'b0010);
    tick;
    chk("bp_nobubble", rr_out_valid, 1'b1);
    chk("bp_sel_next", rr_out_sel,   2'd1);
    chk("bp_data_next", rr_out_data, 32'hD1);

    // Reset after the first beat of a channel-3 packet
    in_valid = 4'b1000;
    in_last  = 4'b0111;
    set_ch(3, 32'hE0);
    #1;
    chk("mr_ready", rr_in_ready, 4'b1000);
    tick;
    chk("mr_sel",  rr_out_sel,  2'd3);
    chk("mr_data", rr_out_data, 32'hE0);
    rst = 1'b1;
    set_ch(3, 32'hE1);
    tick;
    chk("mr_valid", rr_out_valid, 1'b0);
    chk("mr_valid_fp", fp_out_valid, 1'b0);
    rst      = 1'b0;
    in_valid = 4'b1001;
    in_last  = 4'b1111;
    set_ch(0, 32'hF0);
    #1;
    chk("mr_unlock", rr_in_ready, 4'b0001);
    tick;
    chk("mr_sel_next",  rr_out_sel,  2'd0);
    chk("mr_data_next", rr_out_data, 32'hF0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
